// File: rtl/uart_tx_periph.sv
// Bus-mapped UART transmitter: TXDATA at 0x0 feeds a small FIFO, STATUS at 0x4 reads {overflow, full, busy}.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_periph #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ovf_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic full, busy, push_req, push, pop, baud_end, unused_wdata;

    assign unused_wdata = ^wData[31:8];
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign busy     = (state_q != IDLE) || (count_q != '0);
    assign push_req = sel && we && (addr == 4'h0);
    // Fullness uses the registered count, so a pop in the same cycle does not rescue a push.
    assign push     = push_req && !full;
    assign baud_end = (baud_q == 16'(CLK_DIV - 1));
    assign tx       = tx_q;

    always_comb begin
        rData = '0;
        if (sel && addr == 4'h4) rData = {29'b0, ovf_q, full, busy};
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            IDLE:  if (count_q != '0) begin pop = 1'b1; state_d = START; end
            START: if (baud_end) begin state_d = DATA; bit_idx_d = 3'd0; end
            DATA: begin
                if (baud_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (baud_end) state_d = STOP;
`endif
            STOP: begin
                // Back-to-back frames: go straight to START when more data is queued.
                if (baud_end) begin
                    if (count_q != '0) begin pop = 1'b1; state_d = START; end
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = mem_q[rptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = ^mem_q[rptr_q];
`endif
        end

        baud_d = (state_d != state_q || baud_end || state_q == IDLE) ? 16'd0 : baud_q + 16'd1;

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase

        ovf_d = ovf_q;
        if (push_req && full)                   ovf_d = 1'b1;
        else if (sel && we && addr == 4'h4)     ovf_d = 1'b0;

        wptr_d  = wptr_q + PW'(push);
        rptr_d  = rptr_q + PW'(pop);
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wData[7:0];
    end
endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed + randomized bench for uart_tx_periph; the model predicts the tx line per cycle from frame timing rules.
module tb_uart_tx_periph;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int MAXC    = 8192;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0, reset = 1'b1, sel = 1'b0, we = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wData = '0;
    logic [31:0] rData;
    logic        tx;

    int   cyc = 0;
    int   vectors = 0, miscompares = 0;
    logic mon_en = 1'b0;

    // Model state: expected tx after each edge, accepted bytes' push/start edges, line availability.
    logic exp_tx [MAXC];
    int   push_e[$], start_e[$];
    int   line_free = 0;
    logic ovf_m = 1'b0;

    uart_tx_periph #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr),
        .wData(wData), .rData(rData), .tx(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bytes in the FIFO during the cycle after edge e: pushed at or before e, not yet popped.
    function automatic int occ(input int e);
        int n = 0;
        foreach (push_e[i]) if (push_e[i] <= e && start_e[i] > e) n++;
        return n;
    endfunction

    function automatic logic fbit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NBITS == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    function automatic void model_push(input int n, input logic [7:0] b);
        int st;
        if (occ(n - 1) == DEPTH) begin
            ovf_m = 1'b1;
            return;
        end
        st = (n + 1 > line_free) ? n + 1 : line_free;
        for (int k = 0; k < NBITS; k++)
            for (int c = 0; c < CLK_DIV; c++)
                if (st + k * CLK_DIV + c < MAXC) exp_tx[st + k * CLK_DIV + c] = fbit(b, k);
        push_e.push_back(n);
        start_e.push_back(st);
        line_free = st + NBITS * CLK_DIV;
    endfunction

    function automatic logic [31:0] exp_status(input int e);
        int o = occ(e);
        return {29'b0, ovf_m, o == DEPTH, (o > 0) || (e < line_free)};
    endfunction

    task automatic wait_until(input int t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        int n = cyc + 1;
        if (a == 4'h0) model_push(n, d[7:0]);
        if (a == 4'h4) ovf_m = 1'b0;
        sel = 1'b1; we = 1'b1; addr = a; wData = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input string tag);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(tag, rData, (a == 4'h4) ? exp_status(cyc) : 32'h0);
        sel = 1'b0;
    endtask

    task automatic do_reset(input int ncyc);
        int r = cyc + 1;
        for (int i = r; i < MAXC; i++) exp_tx[i] = 1'b1;
        push_e.delete(); start_e.delete();
        ovf_m = 1'b0; line_free = 0;
        reset = 1'b1;
        repeat (ncyc) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    initial begin
        int n0, len;
        for (int i = 0; i < MAXC; i++) exp_tx[i] = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (mon_en && cyc < MAXC) chk($sformatf("tx@%0d", cyc), {31'b0, tx}, {31'b0, exp_tx[cyc]});
            end
        join_none

        do_reset(3);
        mon_en = 1'b1;
        rd(4'h4, "status_after_reset");
        wait_until(cyc + 20);
        rd(4'h4, "status_idle");
        rd(4'h0, "txdata_reads_zero");

        // Single frame 0x55; busy drops exactly one full frame after tx goes low.
        wr(4'h0, 32'h55);
        n0 = cyc;
        wait_until(n0 + NBITS * CLK_DIV);
        rd(4'h4, "busy_last_cycle");
        wait_until(n0 + NBITS * CLK_DIV + 1);
        rd(4'h4, "busy_cleared");
        wait_until(cyc + 5);

        // The first byte leaves the FIFO one edge after its push, so a sixth write is what overflows.
        n0 = cyc + 1;
        for (int i = 1; i <= 6; i++) wr(4'h0, i);
        rd(4'h4, "status_overflow_full");
        wr(4'h4, 32'h0);
        rd(4'h4, "status_ovf_cleared");
        // Push while full on the very edge the next byte is popped: still dropped.
        wait_until(n0 + NBITS * CLK_DIV);
        wr(4'h0, 32'h77);
        rd(4'h4, "status_full_pop_same_edge");
        wr(4'h4, 32'hFFFF_FFFF);
        rd(4'h4, "status_ovf_cleared2");
        wait_until(line_free + 2);
        rd(4'h4, "status_drained");

        // Reset six cycles into a frame aborts it.
        wr(4'h0, 32'hA3);
        n0 = cyc;
        wait_until(n0 + 6);
        do_reset(1);
        rd(4'h4, "status_after_abort");
        wait_until(cyc + 50);
        rd(4'h4, "status_idle_after_abort");

        // Unmapped offsets and deselected reads.
        wr(4'h8, 32'h12);
        rd(4'h8, "read_0x8");
        rd(4'hC, "read_0xC");
        rd(4'h4, "status_no_push");
        wr(4'h0, 32'h07);
        sel = 1'b0; addr = 4'h4; #1;
        chk("rdata_sel0", rData, 32'h0);
        wait_until(line_free + 2);
        rd(4'h4, "status_after_07");

        for (int b = 0; b < 10; b++) begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) wr(4'h0, $urandom);
            rd(4'h4, $sformatf("rand_status_%0d", b));
            if ($urandom_range(0, 1) == 1) begin
                wr(4'h4, $urandom);
                rd(4'h4, $sformatf("rand_clr_%0d", b));
            end
            wait_until(cyc + $urandom_range(0, 60));
        end
        wait_until(line_free + 2);
        rd(4'h4, "status_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
